// File: rtl/ed25519_sc_pkg.sv
// Shared constants, state encoding and helpers for the Ed25519 verifier
// scalar front end (canonical-S check, h mod L, negation).
package ed25519_sc_pkg;

    localparam int SC_W       = 253;
    localparam int HASH_W_DEF = 512;

    // Prime order of the Ed25519 base-point subgroup.
    localparam logic [SC_W-1:0] L =
        253'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        REDUCE = 3'd2,
        NEGATE = 3'd3,
        FINISH = 3'd4
    } sv_state_t;

    // S is canonical when it fits in 253 bits and is strictly below L.
    function automatic logic sc_canonical(input logic [255:0] s);
        return (s[255:253] == 3'd0) && (s[252:0] < L);
    endfunction

endpackage

// File: rtl/ed25519_scalar_verify_sc_mod_l_serial.sv
// Bit-serial reducer: din mod L, one input bit per clock, MSB first.
// Each step shifts the remainder left by one bit and does a single
// conditional subtract of L, which is exact because rem < L implies
// the shifted value is below 2L.
// done is high during the final step; dout holds the finished remainder
// from the following cycle until the next start.
module sc_mod_l_serial
    import ed25519_sc_pkg::*;
#(
    parameter int HASH_W = HASH_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [HASH_W-1:0] din,
    output logic [SC_W-1:0]   dout,
    output logic              done,
    output logic              busy
);

    localparam int CNT_W = (HASH_W > 1) ? $clog2(HASH_W) : 1;

    logic [SC_W-1:0]  rem_r;
    logic [CNT_W-1:0] cnt_r;
    logic             run_r;
    logic             last_r;

    logic [SC_W:0]    t_s;
    logic [SC_W:0]    t_sub_s;
    logic [SC_W-1:0]  rem_next_s;

    // One reduction step: shift in the current hash bit, subtract L if needed.
    always_comb begin
        t_s        = {rem_r, din[cnt_r]};
        t_sub_s    = t_s - {1'b0, L};
        rem_next_s = t_s[SC_W-1:0];
        if (t_s >= {1'b0, L}) begin
            rem_next_s = t_sub_s[SC_W-1:0];
        end else begin
            rem_next_s = t_s[SC_W-1:0];
        end
    end

    // Remainder, bit counter and run/last flags; start is ignored while running.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_r  <= {SC_W{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            run_r  <= 1'b0;
            last_r <= 1'b0;
        end else if (start && !run_r) begin
            rem_r  <= {SC_W{1'b0}};
            cnt_r  <= CNT_W'(HASH_W - 1);
            run_r  <= 1'b1;
            last_r <= (HASH_W == 1);
        end else if (run_r) begin
            rem_r  <= rem_next_s;
            cnt_r  <= cnt_r - CNT_W'(1);
            last_r <= (cnt_r == CNT_W'(1));
            run_r  <= !last_r;
        end
    end

    assign dout = rem_r;
    assign done = last_r;
    assign busy = run_r;

endmodule

// File: rtl/ed25519_scalar_verify.sv
// Ed25519 verifier scalar front end: checks S < L, reduces the challenge
// hash modulo L and emits k_neg = (L - h mod L) mod L for the point engine.
module ed25519_scalar_verify
    import ed25519_sc_pkg::*;
#(
    parameter int HASH_W = HASH_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [255:0]      s_in,
    input  logic [HASH_W-1:0] h_in,
    output logic [SC_W-1:0]   k_neg,
    output logic              s_ok,
    output logic              done,
    output logic              busy
);

    sv_state_t         state_r;
    sv_state_t         state_s;
    logic [255:0]      s_q_r;
    logic [HASH_W-1:0] h_q_r;
    logic [SC_W-1:0]   k_neg_r;
    logic              s_ok_r;
    logic              done_r;

    logic              s_ok_next_s;
    logic              mod_start_s;
    logic [SC_W-1:0]   mod_dout_s;
    logic              mod_done_s;
    logic              mod_busy_s;

    sc_mod_l_serial #(
        .HASH_W (HASH_W)
    ) u_mod (
        .clk   (clk),
        .rst   (rst),
        .start (mod_start_s),
        .din   (h_q_r),
        .dout  (mod_dout_s),
        .done  (mod_done_s),
        .busy  (mod_busy_s)
    );

    // Canonical check on the shadowed S; the reducer is launched only for a good S.
    always_comb begin
        s_ok_next_s = sc_canonical(s_q_r);
        mod_start_s = 1'b0;
        if (state_r == CHECK) begin
            mod_start_s = s_ok_next_s;
        end else begin
            mod_start_s = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = CHECK;
                end else begin
                    state_s = IDLE;
                end
            end
            CHECK: begin
                if (s_ok_next_s) begin
                    state_s = REDUCE;
                end else begin
                    state_s = FINISH;
                end
            end
            REDUCE: begin
                if (mod_done_s) begin
                    state_s = NEGATE;
                end else if (!mod_busy_s) begin
                    // Reducer lost its run flag: close out rather than hang.
                    state_s = FINISH;
                end else begin
                    state_s = REDUCE;
                end
            end
            NEGATE:  state_s = FINISH;
            FINISH:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register, input shadows and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            s_q_r   <= 256'd0;
            h_q_r   <= {HASH_W{1'b0}};
            k_neg_r <= {SC_W{1'b0}};
            s_ok_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            done_r  <= (state_r == FINISH);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        s_q_r <= s_in;
                        h_q_r <= h_in;
                    end
                end
                CHECK: begin
                    s_ok_r <= s_ok_next_s;
                    if (!s_ok_next_s) begin
                        k_neg_r <= {SC_W{1'b0}};
                    end
                end
                NEGATE: begin
                    if (mod_dout_s == {SC_W{1'b0}}) begin
                        k_neg_r <= {SC_W{1'b0}};
                    end else begin
                        k_neg_r <= L - mod_dout_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign k_neg = k_neg_r;
    assign s_ok  = s_ok_r;
    assign done  = done_r;
    assign busy  = (state_r != IDLE);

endmodule
